pul_period_fetch: RTL and testbench

Prefetch buffer upstream of the motor pulse controller. It streams a profile of 32-bit pulse-period words from DDR through a simple request/grant/response read port into a small FIFO. It hands one word to the controller per `read` strobe on the registered `pul_value` output. The credit scheme keeps requests in flight so the controller sees no underrun at normal step rates.

---
 rtl/pul_period_fetch.sv | 157 +++++++++++++++
 tb/tb_pul_period_fetch.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pul_period_fetch.sv
// rtl/pul_period_fetch.sv - pulse-period prefetch buffer: credit-limited memory reads into a FIFO,
// one word handed to the pulse controller per read strobe.
module pul_period_fetch #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       word_count,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              read,
  output logic [31:0]       pul_value,
  output logic              empty,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       wc_r;
  logic [31:0]       req_cnt;
  logic [31:0]       pop_cnt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [31:0]       fifo_mem [DEPTH];

  logic              active;
  logic              grant;
  logic              push;
  logic              pop;
  logic [31:0]       req_next;
  logic [CW-1:0]     out_next;
  logic [CW-1:0]     fifo_next;
  logic [CW:0]       credit_sum;
  logic              credit_ok;

  // abort outranks push and pop in the cycle it arrives
  assign active = (state == FETCH) || (state == DRAIN);
  assign grant  = mem_req && mem_gnt;
  assign push   = active && !abort && mem_rvalid;
  assign pop    = active && !abort && read && (fifo_cnt != '0);
  assign empty  = (fifo_cnt == '0);
  assign busy   = (state != IDLE);

  always_comb begin
    req_next   = req_cnt + {31'd0, grant};
    out_next   = outstanding + CW'(grant) - CW'(mem_rvalid);
    fifo_next  = fifo_cnt + CW'(push) - CW'(pop);
    credit_sum = {1'b0, fifo_next} + {1'b0, out_next};
    credit_ok  = credit_sum < DEPTH_C;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_r      <= '0;
      wc_r        <= '0;
      req_cnt     <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      pul_value   <= '0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            underrun <= 1'b0;
            base_r   <= base_addr;
            wc_r     <= word_count;
            req_cnt  <= '0;
            pop_cnt  <= '0;
            if (word_count == 32'd0) begin
              done <= 1'b1;
            end else begin
              state    <= FETCH;
              mem_req  <= 1'b1;
              mem_addr <= base_addr;
            end
          end
        end
        FETCH, DRAIN: begin
          if (abort) begin
            // a grant in this cycle still gets a response, so it is counted
            state       <= FLUSH;
            mem_req     <= 1'b0;
            outstanding <= out_next;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
          end else begin
            outstanding <= out_next;
            fifo_cnt    <= fifo_next;
            req_cnt     <= req_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
              rd_ptr    <= rd_ptr + 1'b1;
              pul_value <= fifo_mem[rd_ptr];
              pop_cnt   <= pop_cnt + 32'd1;
            end
            if (read && empty) underrun <= 1'b1;
            if (state == FETCH) begin
              if (grant && (req_next == wc_r)) begin
                state   <= DRAIN;
                mem_req <= 1'b0;
              end else if (!mem_req || grant) begin
                mem_req  <= credit_ok;
                mem_addr <= base_r + ADDR_W'({req_next, 2'b00});
              end
            end else if (pop && ((pop_cnt + 32'd1) == wc_r)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (outstanding == '0) begin
            state    <= IDLE;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
          end else if (mem_rvalid) begin
            outstanding <= outstanding - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pul_period_fetch.sv
// tb/tb_pul_period_fetch.sv - scoreboard bench for pul_period_fetch with an in-order latency memory model.
module tb_pul_period_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [31:0] word_count;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        read;
  logic [31:0] pul_value;
  logic        empty;
  logic        busy;
  logic        done;
  logic        underrun;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 2;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gaddr_q[$];
  resp_t       pend[$];

  pul_period_fetch #(.DEPTH(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .read(read),
    .pul_value(pul_value), .empty(empty), .busy(busy), .done(done),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // one clock; records grants, plays back responses after lat cycles, clears pulses
  task automatic tick();
    bit          g;
    logic [31:0] a;
    resp_t       r;
    g = mem_req && mem_gnt;
    a = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    start      = 1'b0;
    abort      = 1'b0;
    read       = 1'b0;
    mem_rvalid = 1'b0;
    if (g) begin
      gaddr_q.push_back(a);
      exp_q.push_back(mdata(a));
      r.due  = cyc - 1 + lat;
      r.data = mdata(a);
      pend.push_back(r);
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
      void'(pend.pop_front());
    end
    if (done) done_cnt++;
  endtask

  task automatic begin_profile(input logic [31:0] b, input logic [31:0] n);
    exp_q.delete();
    gaddr_q.delete();
    done_cnt   = 0;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_req, empty, busy, done, underrun} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags got %b want 01000", {mem_req, empty, busy, done, underrun});
    end
    checks++;
    if (mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", mem_addr);
    end
    checks++;
    if (pul_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_pul got %h want 0", pul_value);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] e;
    mem_gnt = 1'b0;
    begin_profile(32'h3000, 32'd3);
    repeat (3) tick();
    read = 1'b1;
    tick();
    checks++;
    if (underrun !== 1'b1 || pul_value !== 32'd0) begin
      errors++;
      $display("FAIL underrun_set got u=%b pul=%h want u=1 pul=0", underrun, pul_value);
    end
    repeat (14) tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL underrun_hold got req=%b addr=%h want req=1 addr=3000", mem_req, mem_addr);
    end
    mem_gnt = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      read = 1'b1;
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underrun_pop%0d got no expected word want one queued", i);
      end else begin
        e = exp_q.pop_front();
        if (pul_value !== e) begin
          errors++;
          $display("FAIL underrun_pop%0d got %h want %h", i, pul_value, e);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underrun_done got done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    mem_gnt = 1'b1;
    begin_profile(32'h1000, 32'd5);
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h1000 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_start got busy=%b req=%b addr=%h u=%b want 1 1 1000 0",
               busy, mem_req, mem_addr, underrun);
    end
    for (int i = 0; i < 5; i++) begin
      repeat (9) tick();
      read = 1'b1;
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL basic_pop%0d got no expected word want one queued", i);
      end else begin
        e = exp_q.pop_front();
        if (pul_value !== e) begin
          errors++;
          $display("FAIL basic_pop%0d got %h want %h", i, pul_value, e);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b want 1 0", done, busy);
    end
    repeat (3) tick();
    checks++;
    if (done_cnt !== 1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_once got done_cnt=%0d u=%b want 1 0", done_cnt, underrun);
    end
    checks++;
    if (gaddr_q.size() != 5) begin
      errors++;
      $display("FAIL basic_nreq got %0d want 5", gaddr_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (gaddr_q[i] !== 32'h1000 + 32'(4 * i)) begin
          errors++;
          $display("FAIL basic_addr%0d got %h want %h", i, gaddr_q[i], 32'h1000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_credit();
    logic [31:0] e;
    mem_gnt = 1'b1;
    begin_profile(32'h2000, 32'd40);
    repeat (100) tick();
    checks++;
    if (gaddr_q.size() != 16 || mem_req !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL credit_full got grants=%0d req=%b empty=%b want 16 0 0",
               gaddr_q.size(), mem_req, empty);
    end
    for (int k = 0; k < 3; k++) begin
      read = 1'b1;
      tick();
      checks++;
      e = exp_q.pop_front();
      if (pul_value !== e || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL credit_pop%0d got pul=%h req=%b want %h 1", k, pul_value, mem_req, e);
      end
      tick();
      checks++;
      if (mem_req !== 1'b0 || gaddr_q.size() != 17 + k ||
          gaddr_q[gaddr_q.size()-1] !== 32'h2000 + 32'(4 * (16 + k))) begin
        errors++;
        $display("FAIL credit_refill%0d got req=%b grants=%0d want 0 %0d", k, mem_req,
                 gaddr_q.size(), 17 + k);
      end
      repeat (5) tick();
    end
    abort = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if (mem_req !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL credit_abort got req=%b empty=%b want 0 1", mem_req, empty);
    end
    for (int i = 0; i < 50 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL credit_idle got busy=%b done_cnt=%0d want 0 0", busy, done_cnt);
    end
  endtask

  task automatic test_abort();
    logic [31:0] e;
    lat     = 6;
    mem_gnt = 1'b1;
    begin_profile(32'h4000, 32'd100);
    repeat (4) tick();
    mem_gnt = 1'b0;
    abort   = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if (mem_req !== 1'b0 || empty !== 1'b1 || busy !== 1'b1 || pend.size() != 4) begin
      errors++;
      $display("FAIL abort_next got req=%b empty=%b busy=%b pending=%0d want 0 1 1 4",
               mem_req, empty, busy, pend.size());
    end
    for (int i = 0; i < 30 && (pend.size() > 0 || mem_rvalid); i++) tick();
    checks++;
    if (busy !== 1'b1 || pend.size() != 0) begin
      errors++;
      $display("FAIL abort_wait got busy=%b pending=%0d want 1 0", busy, pend.size());
    end
    for (int i = 0; i < 10 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done_cnt=%0d empty=%b want 0 0 1",
               busy, done_cnt, empty);
    end
    lat     = 2;
    mem_gnt = 1'b1;
    begin_profile(32'h5000, 32'd2);
    repeat (8) tick();
    for (int i = 0; i < 2; i++) begin
      read = 1'b1;
      tick();
      checks++;
      e = exp_q.pop_front();
      if (pul_value !== e || gaddr_q[i] !== 32'h5000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL abort_clean%0d got pul=%h addr=%h want %h %h", i, pul_value,
                 gaddr_q[i], e, 32'h5000 + 32'(4 * i));
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_clean_done got done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_edges();
    logic [31:0] e;
    logic [31:0] wa [4];
    wa[0] = 32'hffff_fff8;
    wa[1] = 32'hffff_fffc;
    wa[2] = 32'h0000_0000;
    wa[3] = 32'h0000_0004;
    mem_gnt = 1'b1;
    begin_profile(32'h8000, 32'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b req=%b want 1 0 0", done, busy, mem_req);
    end
    tick();
    checks++;
    if (done !== 1'b0 || gaddr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_after got done=%b grants=%0d want 0 0", done, gaddr_q.size());
    end
    begin_profile(32'hffff_fff8, 32'd4);
    base_addr  = 32'h7000;
    word_count = 32'd9;
    start      = 1'b1;
    tick();
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      read = 1'b1;
      tick();
      checks++;
      e = exp_q.pop_front();
      if (pul_value !== e) begin
        errors++;
        $display("FAIL wrap_pop%0d got %h want %h", i, pul_value, e);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gaddr_q.size() != 4) begin
      errors++;
      $display("FAIL wrap_done got done=%b busy=%b grants=%0d want 1 0 4", done, busy,
               gaddr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (gaddr_q[i] !== wa[i]) begin
          errors++;
          $display("FAIL wrap_addr%0d got %h want %h", i, gaddr_q[i], wa[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1'b1;
    begin_profile(32'h6000, 32'd20);
    repeat (9) tick();
    checks++;
    if (mem_req !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got req=%b empty=%b want 1 0", mem_req, empty);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, empty, busy, done, underrun} !== 5'b01000 || mem_addr !== 32'd0 ||
        pul_value !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got flags=%b addr=%h pul=%h want 01000 0 0",
               {mem_req, empty, busy, done, underrun}, mem_addr, pul_value);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10 && pend.size() > 0; i++) tick();
    tick();
    checks++;
    if (empty !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || pend.size() != 0) begin
      errors++;
      $display("FAIL mid_late got empty=%b busy=%b req=%b pending=%0d want 1 0 0 0",
               empty, busy, mem_req, pend.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    read       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_underrun();
    test_basic();
    test_credit();
    test_abort();
    test_edges();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
